// File: rtl/accu_step_arbiter_if.sv
// Handshake and accumulator-side signals of the two-requester step arbiter.
// Master drives requests and the accumulator flag; slave is the arbiter.
interface accu_step_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       req;
  logic [1:0]       bit_in;
  logic             acc_out;
  logic             acc_in;
  logic             acc_next;
  logic [1:0]       ack;
  logic [1:0]       hit;
  logic [CNT_W-1:0] hit_cnt0;
  logic [CNT_W-1:0] hit_cnt1;
  logic             busy;
  logic             last_grant;

  modport master (
    output req, bit_in, acc_out,
    input  acc_in, acc_next, ack, hit, hit_cnt0, hit_cnt1, busy, last_grant
  );

  modport slave (
    input  req, bit_in, acc_out,
    output acc_in, acc_next, ack, hit, hit_cnt0, hit_cnt1, busy, last_grant
  );
endinterface

// File: rtl/accu_step_arbiter.sv
// Round-robin sharing of one edge-stepped accumulator between two requesters,
// with per-requester terminal-count routing and saturating hit counters.
//
// state  | meaning
// IDLE   | arbitrate; report hit of the step just finished
// DRIVE  | acc_next high for HOLD cycles, ack in first cycle
// SETTLE | acc_next low for GAP cycles, acc_out sampled in last cycle
module accu_step_arbiter #(
  parameter int HOLD  = 2,
  parameter int GAP   = 3,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                reset,
  accu_step_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int TMR_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             owner_q, owner_d;
  logic             bit_q, bit_d;
  logic             last_q, last_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       hit_q, hit_d;
  logic             acc_next_q, acc_next_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             win;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      owner_q    <= 1'b0;
      bit_q      <= 1'b0;
      last_q     <= 1'b1;
      ack_q      <= 2'b00;
      hit_q      <= 2'b00;
      acc_next_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      owner_q    <= owner_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      acc_next_q <= acc_next_d;
      busy_q     <= busy_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    owner_d    = owner_q;
    bit_d      = bit_q;
    last_d     = last_q;
    ack_d      = 2'b00;
    hit_d      = 2'b00;
    acc_next_d = 1'b0;
    busy_d     = 1'b0;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    // Contention goes to the requester not served last; a lone request always wins.
    win        = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          owner_d    = win;
          bit_d      = bus.bit_in[win];
          last_d     = win;
          ack_d      = win ? 2'b10 : 2'b01;
          acc_next_d = 1'b1;
          busy_d     = 1'b1;
          tmr_d      = TW'(HOLD - 1);
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        if (tmr_q == '0) begin
          tmr_d   = TW'(GAP - 1);
          state_d = SETTLE;
        end else begin
          tmr_d      = tmr_q - TW'(1);
          acc_next_d = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          // acc_out has had at least one cycle to settle after the strobe rose.
          if (bus.acc_out) begin
            hit_d = owner_q ? 2'b10 : 2'b01;
            if (owner_q) begin
              if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
              if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
            end
          end
        end else begin
          tmr_d  = tmr_q - TW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.acc_in     = bit_q;
  assign bus.acc_next   = acc_next_q;
  assign bus.ack        = ack_q;
  assign bus.hit        = hit_q;
  assign bus.hit_cnt0   = cnt0_q;
  assign bus.hit_cnt1   = cnt1_q;
  assign bus.busy       = busy_q;
  assign bus.last_grant = last_q;

endmodule

// File: tb/tb_accu_step_arbiter.sv
// Randomized bench: two arbiters (8-bit and 2-bit counters) share stimulus,
// each stepping its own behavioural accumulator that flags every fourth '1'.
module tb_accu_step_arbiter;
  localparam int HOLD = 2;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_s;
  logic [1:0] bit_s;

  always #5 clk = ~clk;

  accu_step_arbiter_if #(.CNT_W(8)) if0 ();
  accu_step_arbiter_if #(.CNT_W(2)) if1 ();

  accu_step_arbiter #(.HOLD(HOLD), .GAP(GAP), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  accu_step_arbiter #(.HOLD(HOLD), .GAP(GAP), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  assign if0.req    = req_s;
  assign if0.bit_in = bit_s;
  assign if1.req    = req_s;
  assign if1.bit_in = bit_s;

  // Accumulator plants: count '1' steps on rising acc_next, flag on every fourth.
  int   p0_cnt, p1_cnt;
  logic p0_prev, p1_prev, p0_out, p1_out;
  assign if0.acc_out = p0_out;
  assign if1.acc_out = p1_out;

  always @(posedge clk) begin
    if (!reset) begin
      p0_cnt <= 0; p0_prev <= 1'b0; p0_out <= 1'b0;
    end else begin
      p0_prev <= if0.acc_next;
      if (if0.acc_next && !p0_prev) begin
        if (if0.acc_in) begin
          p0_cnt <= (p0_cnt + 1) % 4;
          p0_out <= (p0_cnt == 3);
        end else p0_out <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      p1_cnt <= 0; p1_prev <= 1'b0; p1_out <= 1'b0;
    end else begin
      p1_prev <= if1.acc_next;
      if (if1.acc_next && !p1_prev) begin
        if (if1.acc_in) begin
          p1_cnt <= (p1_cnt + 1) % 4;
          p1_out <= (p1_cnt == 3);
        end else p1_out <= 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: a grant at edge g owns edges g..g+HOLD+GAP.
  int k = 0;
  int g = 0;
  int in_step = 0;
  int owner = 0;
  int step_hit = 0;
  int last = 1;
  int ones = 0;
  int c0 = 0, c1 = 0, s0 = 0, s1 = 0;
  int e_ack = 0, e_next = 0, e_busy = 0, e_hit = 0, e_in = 0;

  task automatic model(input logic rb, input logic [1:0] rq, input logic [1:0] bi);
    int off;
    e_ack = 0;
    e_hit = 0;
    if (!rb) begin
      in_step = 0; last = 1; ones = 0;
      c0 = 0; c1 = 0; s0 = 0; s1 = 0;
      e_next = 0; e_busy = 0; e_in = 0;
    end else if (in_step != 0) begin
      off = k - g;
      if (off < HOLD) begin
        e_next = 1; e_busy = 1;
      end else if (off < HOLD + GAP) begin
        e_next = 0; e_busy = 1;
      end else begin
        e_next = 0; e_busy = 0; in_step = 0;
        if (step_hit != 0) begin
          e_hit = (owner == 1) ? 2 : 1;
          if (owner == 1) begin
            c1 = (c1 < 255) ? c1 + 1 : c1;
            s1 = (s1 < 3) ? s1 + 1 : s1;
          end else begin
            c0 = (c0 < 255) ? c0 + 1 : c0;
            s0 = (s0 < 3) ? s0 + 1 : s0;
          end
        end
      end
    end else if (rq != 2'b00) begin
      if (rq == 2'b11) owner = 1 - last;
      else owner = rq[1] ? 1 : 0;
      last = owner;
      g = k; in_step = 1;
      e_ack = (owner == 1) ? 2 : 1;
      e_next = 1; e_busy = 1;
      e_in = int'(bi[owner]);
      step_hit = (e_in == 1 && ones == 3) ? 1 : 0;
      ones = (step_hit != 0) ? 0 : ones + e_in;
    end else begin
      e_next = 0; e_busy = 0;
    end
  endtask

  task automatic cyc(input logic rb, input logic [1:0] rq, input logic [1:0] bi);
    reset = rb; req_s = rq; bit_s = bi;
    @(posedge clk);
    model(rb, rq, bi);
    k++;
    @(negedge clk);
    chk("ack",        int'(if0.ack),        e_ack);
    chk("acc_next",   int'(if0.acc_next),   e_next);
    chk("acc_in",     int'(if0.acc_in),     e_in);
    chk("busy",       int'(if0.busy),       e_busy);
    chk("hit",        int'(if0.hit),        e_hit);
    chk("hit_cnt0",   int'(if0.hit_cnt0),   c0);
    chk("hit_cnt1",   int'(if0.hit_cnt1),   c1);
    chk("last_grant", int'(if0.last_grant), last);
    chk("w2_hit",     int'(if1.hit),        e_hit);
    chk("w2_cnt0",    int'(if1.hit_cnt0),   s0);
    chk("w2_cnt1",    int'(if1.hit_cnt1),   s1);
  endtask

  initial begin
    int waited;
    reset = 1'b0; req_s = 2'b11; bit_s = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11, 2'b11);
    // First contention after reset must go to requester 0.
    cyc(1'b1, 2'b11, 2'b11);
    chk("first_grant", int'(if0.ack), 1);

    for (int i = 0; i < 40; i++) cyc(1'b1, 2'b01, 2'b01);
    for (int i = 0; i < 60; i++) cyc(1'b1, 2'b11, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 140; i++) cyc(1'b1, 2'b10, 2'b11);

    // Reset sampled at the end of the second DRIVE cycle.
    waited = 0;
    while (e_ack == 0 && waited < 20) begin
      cyc(1'b1, 2'b01, 2'b11);
      waited++;
    end
    chk("wait_ack", (waited < 20) ? 1 : 0, 1);
    cyc(1'b1, 2'b01, 2'b11);
    cyc(1'b0, 2'b01, 2'b11);
    chk("rst_mid_next", int'(if0.acc_next), 0);
    cyc(1'b1, 2'b01, 2'b11);
    chk("rst_regrant", int'(if0.ack), 1);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    cyc(1'b1, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/accu_step_arbiter.md
Name: accu_step_arbiter

Overview:
- Shares one edge-stepped accumulator FSM between two requesters.
- Accumulator interface: data bit `in`, rising-edge step strobe `next`, terminal-count flag `out`.
- Round-robin arbitration; drives a clean high/low step pulse so the accumulator's edge detector registers exactly one step per grant.
- Routes each terminal-count hit back to the requester whose step caused it, and counts hits per requester.

Parameters:
HOLD, 2, cycles acc_next is held high per step (>=1)
GAP, 3, cycles acc_next is held low after the high phase, before re-arbitration (>=1)
CNT_W, 8, width of each per-requester saturating hit counter

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low reset
req  input  2  per-requester step request, level; bit i = requester i
bit_in  input  2  per-requester data bit, sampled at grant
acc_out  input  1  accumulator terminal-count flag
acc_in  output  1  data bit to accumulator
acc_next  output  1  step strobe to accumulator
ack  output  2  one-cycle grant acknowledge, one-hot
hit  output  2  one-cycle terminal-count notification, one-hot
hit_cnt0  output  CNT_W  saturating hit count, requester 0
hit_cnt1  output  CNT_W  saturating hit count, requester 1
busy  output  1  high in DRIVE or SETTLE
last_grant  output  1  index of most recently granted requester

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - acc_next, acc_in, ack, hit and busy go to 0.
  - hit_cnt0 and hit_cnt1 go to 0.
  - last_grant goes to 1, so requester 0 wins the first contention.
  - Reset applies in any state. A step cut short mid-DRIVE leaves acc_next low from the next cycle.
  - The top level resets the accumulator at the same time.
- All outputs are registered.
- States: IDLE, DRIVE, SETTLE.
- IDLE:
  - If req==00, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If req==11, grant ~last_grant.
  - On grant: latch owner and bit_in[owner], set last_grant=owner, go to DRIVE.
- DRIVE:
  - Lasts exactly HOLD cycles.
  - acc_next=1 and acc_in=latched bit throughout.
  - ack[owner]=1 in the first DRIVE cycle only.
  - busy=1.
  - req and bit_in are ignored.
- SETTLE:
  - Lasts exactly GAP cycles.
  - acc_next=0, acc_in holds the latched bit, busy=1.
  - At the last SETTLE cycle, sample acc_out. This is valid because the accumulator updates one cycle after the strobe rises.
  - Go to IDLE.
- Hit reporting:
  - If the sampled acc_out==1, hit[owner]=1 for the first IDLE cycle.
  - In that same cycle, the owner's counter increments, saturating at 2^CNT_W-1.
- Timing:
  - Minimum step period is HOLD+GAP+1 cycles.
  - IDLE lasts at least one cycle between steps; there are no back-to-back DRIVE phases.
  - Grant latency: req seen at posedge t gives ack and acc_next high in cycle t+1.
- Request protocol:
  - A requester deasserts req in the cycle after seeing ack.
  - A req still high on the next IDLE evaluation is a new request.
  - A request arriving during DRIVE/SETTLE waits until IDLE and is never dropped if held.
- Round-robin rule:
  - Under continuous req==11, grants strictly alternate 0,1,0,1.
  - A single active requester is granted every period regardless of last_grant.
- Saturation: a counter at max stays at max; hit still pulses.
- acc_in changes only at the IDLE->DRIVE transition, never while acc_next is high.

Test Plan:
- Reset held 3 cycles with req=11 -> no ack, acc_next=0, hit_cnt0=hit_cnt1=0, last_grant=1; after release, first grant is ack=01.
- Requester 0 alone, bit_in=1, four requests, HOLD=2, GAP=3:
  - Each step gives acc_next high 2 cycles, low 3 cycles, period 6.
  - Fourth step gives hit=01 for one cycle and hit_cnt0=1.
- req=11 held for 6 steps -> ack sequence 01,10,01,10,01,10; last_grant toggles each step.
- Interleaved steps:
  - Order: req0 bit 1, req1 bit 1, req0 bit 0, req1 bit 1, req0 bit 1.
  - The fourth '1' is requester 0's final step, giving hit=01 and hit_cnt0=1, hit_cnt1=0.
- Reset asserted in the second DRIVE cycle -> acc_next=0 next cycle, state IDLE, counters cleared; new req then gets ack after one cycle.
- CNT_W=2, 5 hits by requester 1 -> hit_cnt1 goes 1,2,3,3,3; hit pulses all 5 times.
